// File: rtl/float_pkg.sv
// ---------------------------------------------------------------------------
// float_pkg
//   Shared definitions for the floating-point datapath back end: the
//   normalizer (float_normalizer) and the rounding stage (FloatRounding).
//
//   Contents:
//     FP_N          default normalized mantissa width (hidden bit included)
//     FP_EXP        default biased exponent width
//     FP_EXP_ONES   all-ones exponent for the default width (Inf/NaN code)
//     norm_state_t  normalizer FSM state encoding {IDLE, NORM, DONE}
//     exp_ones()    all-ones helper usable at any exponent width up to 32
// ---------------------------------------------------------------------------
package float_pkg;

  localparam int FP_N   = 24;
  localparam int FP_EXP = 8;

  localparam logic [FP_EXP-1:0] FP_EXP_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  // All-ones exponent for an arbitrary width; callers slice the low bits.
  function automatic logic [31:0] exp_ones(input int width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/float_normalizer.sv
// ---------------------------------------------------------------------------
// float_normalizer
//   Iterative normalization stage placed in front of FloatRounding. A raw
//   mantissa {Carry, rawMant} and biased exponent are loaded on Start. The
//   mantissa is shifted left one bit per cycle until its leading one reaches
//   the MSB, the exponent reaches zero (denormal floor), or the mantissa is
//   found to be zero. The n-bit normalized mantissa, exponent, round bit and
//   sticky bit are then presented with a valid/ready handshake.
//
//   Parameters:
//     n    normalized mantissa width (hidden bit included)
//     exp  exponent width
//     M    raw mantissa width, must be >= n+2 (needs a round bit plus at
//          least one sticky bit below the kept mantissa)
//
//   Ports:
//     Clock     in   rising-edge clock
//     Reset     in   synchronous active-low reset
//     Start     in   load request, only looked at in IDLE
//     rawMant   in   raw mantissa [M-1:0]
//     Carry     in   overflow bit sitting just above rawMant
//     rawExp    in   raw biased exponent [exp-1:0]
//     Ready     in   downstream accepts the result
//     Busy      out  high whenever the FSM is not in IDLE
//     Valid     out  result outputs are valid and held stable
//     normMant  out  normalized mantissa [n-1:0]
//     normExp   out  adjusted exponent [exp-1:0]
//     R         out  round bit
//     S         out  sticky bit
//     Overflow  out  result is infinity
//     dbg_state out  current FSM state, for observation only
//
//   Handshake: a result transfers on a rising edge where Valid && Ready are
//   both high; Valid drops on that edge. Valid is never withdrawn without a
//   transfer (except by Reset), and all result outputs hold while Valid is
//   high. Ready while Valid is low has no effect. Start is only accepted in
//   IDLE, so a Start coinciding with the transfer edge is dropped.
// ---------------------------------------------------------------------------
module float_normalizer
  import float_pkg::*;
#(
  parameter int n   = FP_N,
  parameter int exp = FP_EXP,
  parameter int M   = 2 * n
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [M-1:0]   rawMant,
  input  logic           Carry,
  input  logic [exp-1:0] rawExp,
  input  logic           Ready,
  output logic           Busy,
  output logic           Valid,
  output logic [n-1:0]   normMant,
  output logic [exp-1:0] normExp,
  output logic           R,
  output logic           S,
  output logic           Overflow,
  output norm_state_t    dbg_state
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [31:0]    ONES_32   = exp_ones(exp);
  localparam logic [exp-1:0] EXP_ONES  = ONES_32[exp-1:0];
  localparam logic [exp-1:0] EXP_ONE   = {{(exp-1){1'b0}}, 1'b1};
  // rawExp at or above this, plus a carry, would reach or pass all-ones.
  localparam logic [exp-1:0] OVF_LIMIT = EXP_ONES - EXP_ONE;

  // -------------------------------------------------------------------------
  // Working registers
  // -------------------------------------------------------------------------
  norm_state_t    state;
  logic [M-1:0]   work;   // working mantissa
  logic [exp-1:0] e;      // working exponent
  logic           stk;    // sticky bit shifted out by a carry right-shift
  logic           ovf;    // exponent overflowed on the carry increment

  // -------------------------------------------------------------------------
  // Load-time preparation (used only when Start is taken in IDLE)
  // -------------------------------------------------------------------------
  logic [M-1:0]   load_work;
  logic [exp-1:0] load_e;
  logic           load_stk;
  logic           load_ovf;

  always_comb begin
    load_work = rawMant;
    load_e    = rawExp;
    load_stk  = 1'b0;
    load_ovf  = 1'b0;
    if (Carry) begin
      // The carry becomes the new leading one; the bit falling off the
      // bottom is folded into sticky so it is never lost.
      load_work = {1'b1, rawMant[M-1:1]};
      load_stk  = rawMant[0];
      load_e    = rawExp + EXP_ONE;
      load_ovf  = (rawExp >= OVF_LIMIT);
    end
  end

  // -------------------------------------------------------------------------
  // Termination test for NORM
  // -------------------------------------------------------------------------
  logic work_zero;
  logic e_zero;
  logic norm_stop;

  always_comb begin
    work_zero = (work == '0);
    e_zero    = (e == '0);
    // e == 0 is the denormal floor: stop shifting and emit the
    // unnormalized mantissa as is.
    norm_stop = ovf | work[M-1] | e_zero | work_zero;
  end

  // -------------------------------------------------------------------------
  // GRS extraction: builds the result that gets registered on DONE entry
  // -------------------------------------------------------------------------
  logic [n-1:0]   res_mant;
  logic [exp-1:0] res_exp;
  logic           res_r;
  logic           res_s;
  logic           res_ovf;

  always_comb begin
    res_mant = work[M-1 -: n];
    res_exp  = e;
    res_r    = work[M-n-1];
    res_s    = (|work[M-n-2:0]) | stk;
    res_ovf  = 1'b0;
    if (ovf) begin
      // Infinity: all-ones exponent, clean mantissa, nothing to round.
      res_mant = '0;
      res_exp  = EXP_ONES;
      res_r    = 1'b0;
      res_s    = 1'b0;
      res_ovf  = 1'b1;
    end else if (work_zero) begin
      // True zero: exponent forced to zero regardless of the input.
      // stk is always 0 here since a carry load leaves the MSB set.
      res_mant = '0;
      res_exp  = '0;
      res_r    = 1'b0;
      res_s    = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      work     <= '0;
      e        <= '0;
      stk      <= 1'b0;
      ovf      <= 1'b0;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      normMant <= '0;
      normExp  <= '0;
      R        <= 1'b0;
      S        <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            work  <= load_work;
            e     <= load_e;
            stk   <= load_stk;
            ovf   <= load_ovf;
            Busy  <= 1'b1;
            state <= NORM;
          end
        end

        NORM: begin
          if (norm_stop) begin
            normMant <= res_mant;
            normExp  <= res_exp;
            R        <= res_r;
            S        <= res_s;
            Overflow <= res_ovf;
            Valid    <= 1'b1;
            state    <= DONE;
          end else begin
            // e is non-zero here, so the decrement cannot wrap.
            work <= {work[M-2:0], 1'b0};
            e    <= e - EXP_ONE;
          end
        end

        DONE: begin
          // Result outputs are only written on DONE entry, so they hold
          // for as long as Ready stays low.
          if (Ready) begin
            Valid <= 1'b0;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_float_normalizer.sv
// ---------------------------------------------------------------------------
// tb_float_normalizer
//   Directed and randomized checks of float_normalizer (n=24, exp=8, M=48).
//   Expected results come from literal values for the directed cases and
//   from a leading-one/shift-amount reference model for random cases.
// ---------------------------------------------------------------------------
module tb_float_normalizer;
  import float_pkg::*;

  localparam int N  = 24;
  localparam int EW = 8;
  localparam int MW = 48;

  typedef struct {
    logic [N-1:0]  mant;
    logic [EW-1:0] ex;
    logic          r;
    logic          s;
    logic          ovf;
    int            lat;
  } res_t;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [MW-1:0] raw_mant;
  logic          carry;
  logic [EW-1:0] raw_exp;
  logic          ready;
  logic          busy;
  logic          valid;
  logic [N-1:0]  norm_mant;
  logic [EW-1:0] norm_exp;
  logic          r_bit;
  logic          s_bit;
  logic          overflow;
  norm_state_t   dbg_state;

  always #5 clk = ~clk;

  float_normalizer #(.n(N), .exp(EW), .M(MW)) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .Start    (start),
    .rawMant  (raw_mant),
    .Carry    (carry),
    .rawExp   (raw_exp),
    .Ready    (ready),
    .Busy     (busy),
    .Valid    (valid),
    .normMant (norm_mant),
    .normExp  (norm_exp),
    .R        (r_bit),
    .S        (s_bit),
    .Overflow (overflow),
    .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- scoreboard ----------------
  logic [N+EW+3-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Value is {carry, raw}. Shift amount is the number of leading zeros of
  // the (carry-adjusted) mantissa, capped by the exponent.
  function automatic res_t model(input logic [MW-1:0] raw, input logic c, input int rexp);
    res_t          o;
    logic [MW-1:0] w;
    logic          stk;
    int            e;
    int            p;
    int            k;
    o.mant = '0; o.ex = '0; o.r = 1'b0; o.s = 1'b0; o.ovf = 1'b0; o.lat = 2;
    if (c && rexp >= 254) begin
      o.ex  = 8'hFF;
      o.ovf = 1'b1;
      return o;
    end
    w   = c ? ((raw >> 1) | (48'd1 << 47)) : raw;
    stk = c ? raw[0] : 1'b0;
    e   = c ? rexp + 1 : rexp;
    if (w == 0) return o;
    p = -1;
    for (int i = MW - 1; i >= 0; i--) if (w[i] && p < 0) p = i;
    k = (MW - 1 - p < e) ? (MW - 1 - p) : e;
    w = w << k;
    e = e - k;
    o.mant = w[MW-1:MW-N];
    o.r    = w[MW-N-1];
    o.s    = (|w[MW-N-2:0]) | stk;
    o.ex   = e[EW-1:0];
    o.lat  = 2 + k;
    return o;
  endfunction

  function automatic res_t mk(input logic [N-1:0] m, input logic [EW-1:0] x,
                              input logic r, input logic s, input logic ov, input int lat);
    res_t o;
    o.mant = m; o.ex = x; o.r = r; o.s = s; o.ovf = ov; o.lat = lat;
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // One operation: Start, wait for Valid (bounded), compare, optionally hold
  // Ready low while pulsing Start, then transfer.
  task automatic run_op(input string tag, input logic [MW-1:0] raw, input logic c,
                        input logic [EW-1:0] rexp, input logic early_ready,
                        input int hold, input res_t want);
    int cycles;
    logic [N+EW+3-1:0] got_pack;
    logic [N+EW+3-1:0] want_pack;
    raw_mant = raw;
    carry    = c;
    raw_exp  = rexp;
    start    = 1'b1;
    ready    = early_ready;
    exp_q.push_back({want.mant, want.ex, want.r, want.s, want.ovf});
    step();
    check({tag, ".busy_rise"}, 64'(busy), 64'd1);
    start    = 1'b0;
    raw_mant = {$urandom, $urandom};   // inputs must already be captured
    carry    = $urandom_range(0, 1);
    raw_exp  = 8'($urandom);
    cycles   = 1;
    while (!valid && cycles < 100) begin
      step();
      cycles++;
    end
    check({tag, ".latency"}, 64'(cycles), 64'(want.lat));
    if (!valid) begin
      do_reset();
      return;
    end
    want_pack = exp_q.pop_front();
    got_pack  = {norm_mant, norm_exp, r_bit, s_bit, overflow};
    check({tag, ".mant"}, 64'(norm_mant), 64'(want_pack[N+EW+2:EW+3]));
    check({tag, ".exp"},  64'(norm_exp),  64'(want_pack[EW+2:3]));
    check({tag, ".r"},    64'(r_bit),     64'(want_pack[2]));
    check({tag, ".s"},    64'(s_bit),     64'(want_pack[1]));
    check({tag, ".ovf"},  64'(overflow),  64'(want_pack[0]));
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        start    = 1'b1;
        raw_mant = {$urandom, $urandom};
        raw_exp  = 8'($urandom);
        step();
        check({tag, ".hold_valid"}, 64'(valid), 64'd1);
        check({tag, ".hold_out"}, 64'({norm_mant, norm_exp, r_bit, s_bit, overflow}), 64'(got_pack));
      end
      start = 1'b1;   // coincides with the transfer edge, must be dropped
      ready = 1'b1;
    end
    step();
    check({tag, ".valid_fall"}, 64'(valid), 64'd0);
    check({tag, ".busy_fall"},  64'(busy),  64'd0);
    start = 1'b0;
    ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    res_t want;
    logic [MW-1:0] raw;
    logic c;
    logic [EW-1:0] rexp;
    int seen;

    rst_n = 1'b0; start = 1'b0; ready = 1'b0;
    raw_mant = '0; carry = 1'b0; raw_exp = '0;
    do_reset();
    check("rst.busy",  64'(busy), 64'd0);
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.outs",  64'({norm_mant, norm_exp, r_bit, s_bit, overflow}), 64'd0);
    check("rst.state", 64'(dbg_state), 64'(IDLE));

    // Directed cases
    run_op("d1_shift1", 48'h4000_0000_0000, 1'b0, 8'd127, 1'b1, 0,
           mk(24'h800000, 8'd126, 1'b0, 1'b0, 1'b0, 3));
    run_op("d2_carry", 48'h0000_0000_0001, 1'b1, 8'd100, 1'b1, 0,
           mk(24'h800000, 8'd101, 1'b0, 1'b1, 1'b0, 2));
    run_op("d3_zero", 48'h0, 1'b0, 8'd77, 1'b1, 0,
           mk(24'h0, 8'd0, 1'b0, 1'b0, 1'b0, 2));
    run_op("d4_denorm", 48'h0000_0000_0001, 1'b0, 8'd10, 1'b1, 0,
           mk(24'h0, 8'd0, 1'b0, 1'b1, 1'b0, 12));
    run_op("d5_ovf", 48'h1234_5678_9ABC, 1'b1, 8'd254, 1'b1, 0,
           mk(24'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 2));
    run_op("d6_backpr", 48'h0000_00F0_0000, 1'b0, 8'd200, 1'b0, 5,
           mk(24'hF00000, 8'd176, 1'b0, 1'b0, 1'b0, 26));

    // Reset in the middle of NORM: aborts, outputs cleared, no result later
    raw_mant = 48'h0000_0000_0001;
    carry    = 1'b0;
    raw_exp  = 8'd40;
    start    = 1'b1;
    ready    = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("midrst.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    check("midrst.busy",  64'(busy),  64'd0);
    check("midrst.valid", 64'(valid), 64'd0);
    check("midrst.outs",  64'({norm_mant, norm_exp, r_bit, s_bit, overflow}), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (valid || busy) seen++;
    end
    check("midrst.no_result", 64'(seen), 64'd0);
    ready = 1'b0;

    // Randomized operations checked against the reference model
    for (int t = 0; t < 40; t++) begin
      raw  = {$urandom, $urandom} >> $urandom_range(0, 47);
      c    = ($urandom_range(0, 3) == 0);
      rexp = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) raw = '0;
      want = model(raw, c, int'(rexp));
      run_op($sformatf("rnd%0d", t), raw, c, rexp, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), want);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/float_normalizer.md
# float_normalizer

Iterative normalization stage that feeds `FloatRounding` in the floating-point datapath. It accepts a raw, unnormalized mantissa from the arithmetic core (multiplier product or adder sum with carry-out). It shifts that mantissa until its leading one sits in the MSB, adjusting the exponent as it goes. It then presents the `n`-bit normalized mantissa, exponent, round bit R and sticky bit S through a valid/ready handshake, directly matching the rounding stage's `normMant`/`normExp`/`R`/`S` inputs.

## Interface
- `n`, 24: normalized mantissa width (hidden bit included).
- `exp`, 8: exponent width.
- `M`, 2*`n`: raw mantissa width; must satisfy `M` ≥ `n`+2.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-low reset (`Reset`==0 resets on the next rising edge).
- `Start`  in  1  load request; sampled only in IDLE.
- `rawMant`  in  `M`  raw mantissa.
- `Carry`  in  1  overflow bit above `rawMant`; the value is {`Carry`,`rawMant`}.
- `rawExp`  in  `exp`  raw biased exponent.
- `Ready`  in  1  downstream accepts the result.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Valid`  out  1  result outputs are valid and stable.
- `normMant`  out  `n`  normalized mantissa.
- `normExp`  out  `exp`  adjusted exponent.
- `R`  out  1  round bit.
- `S`  out  1  sticky bit.
- `Overflow`  out  1  result is infinity.

## Operation
- Internal registers:
  - `work[M-1:0]`: working mantissa.
  - `e[exp-1:0]`: working exponent.
  - `stk`: accumulated sticky bit.
  - `ovf`: overflow flag.
- States are IDLE, NORM and DONE.
- **IDLE**, on `Start`==1:
  - If `Carry`==1:
    - `work` = {1,`rawMant[M-1:1]`}.
    - `stk` = `rawMant[0]`.
    - `e` = `rawExp`+1.
    - `ovf` = (`rawExp` ≥ 2^`exp`−2).
  - Otherwise: `work` = `rawMant`, `stk` = 0, `e` = `rawExp`, `ovf` = 0.
  - Next state is NORM.
- **NORM**, evaluated each cycle:
  - If `ovf`, or `work[M-1]`, or `e`==0, or `work`==0: go to DONE.
  - Otherwise: `work` <<= 1 (zero fill), `e` -= 1, stay in NORM.
- **DONE**:
  - `Valid`=1.
  - On `Ready`==1, go to IDLE. Otherwise hold all outputs unchanged.
- Output mapping (registered, updated on entry to DONE):
  - `normMant` = `work[M-1 -: n]`.
  - `R` = `work[M-n-1]`.
  - `S` = |`work[M-n-2:0]` | `stk`.
  - `normExp` = `e`.
- Zero result (`work`==0 at NORM): `normExp`=0, `normMant`=0, R=S=0.
- Overflow result: `Overflow`=1, `normExp`=all ones, `normMant`=0, R=S=0.
- Denormal floor: when `e` reaches 0, shifting stops. Output is taken from the unnormalized `work`, with no error flag.
- `Start` is ignored whenever the state is not IDLE. There is no queuing.

## Timing
- Reset values:
  - `Busy`=0, `Valid`=0, `Overflow`=0.
  - `normMant`=0, `normExp`=0, R=S=0.
  - State is IDLE.
- `Reset` low in any state aborts the operation. All outputs take their reset values on the next edge.
- Latency: `Start` sampled at edge t gives NORM from t+1.
  - With k left shifts, `Valid` rises at edge t+2+k.
  - k ≤ `M`−1, so worst case is `Valid` at t+`M`+1.
- `Busy` rises at t+1 and falls on the edge where DONE+`Ready` is taken.
- Handshake: transfer occurs on an edge with `Valid`&&`Ready`. `Valid` drops on that edge.
- `Start` asserted in that same cycle is ignored; the state is not yet IDLE. The earliest accepted `Start` is the cycle after transfer.
- `Ready` asserted early (before `Valid`) has no effect.
- Exponent arithmetic is `exp`-bit unsigned. The decrement never wraps because shifting stops at `e`==0. The increment saturation case is `ovf`.

## Structure
- Shared package `float_pkg`:
  - State enum `norm_state_t` {IDLE, NORM, DONE}.
  - Default width constants `FP_N`=24, `FP_EXP`=8.
  - Exponent all-ones constant.
- The same package is used by `FloatRounding`.
- Single module. No sub-module is required. The GRS extraction (`normMant`/R/S slicing) is a combinational block inside.

## Test plan
Parameters for all scenarios: n=24, exp=8, M=48.
1. `rawMant`=48'h4000_0000_0000, `Carry`=0, `rawExp`=127, `Ready`=1 → `normMant`=24'h800000, `normExp`=126, R=0, S=0, `Valid` at t+3.
2. `Carry`=1, `rawMant`=48'h0000_0000_0001, `rawExp`=100 → `normMant`=24'h800000, `normExp`=101, R=0, S=1, `Valid` at t+2.
3. `rawMant`=0, `Carry`=0, `rawExp`=77 → `normMant`=0, `normExp`=0, R=S=0, `Valid` at t+2.
4. `rawMant`=48'h0000_0000_0001, `rawExp`=10 → 10 shifts, `normExp`=0, `normMant`=0, R=0, S=1, `Valid` at t+12.
5. `Carry`=1, `rawExp`=254 → `Overflow`=1, `normExp`=8'hFF, `normMant`=0, R=S=0, `Valid` at t+2.
6. Back-pressure and reset:
   - Hold `Ready`=0 for 5 cycles after `Valid` while pulsing `Start` with new data → outputs stable, new `Start` ignored.
   - Separately, drive `Reset`=0 mid-NORM → `Busy`=0, `Valid`=0 on the next edge, and no result appears.
